// File: rtl/lr_pkg.sv
// Shared definitions for the linear-regression front end: field width,
// feature capacity, word-width helper and the receiver state encoding.
package lr_pkg;

  // Every value in a data point (target or feature) is a 16-bit field.
  localparam int FIELD_W = 16;

  // Feature capacity the stored buffer word is sized for.
  localparam int MAX_FEATURES = 7;

  // Width of one data point holding n features plus the target y.
  function automatic int data_width(input int n);
    return FIELD_W * (n + 1);
  endfunction

  // Receiver progress: still collecting points, or the full set is captured.
  typedef enum logic {
    RECV = 1'b0,
    DONE = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in / parallel-out shifter, MSB first.
// The parallel output `word` always includes the bit currently on ser_in,
// so a complete W-bit word is available on the same edge that samples its
// last bit. Only W-1 bits need storage for that reason.
module sipo_shift #(
  parameter int W = 112
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  input  logic         ser_in,
  output logic [W-1:0] word
);

  logic [W-2:0] sr;

  // The incoming bit is the LSB of the word being assembled.
  assign word = {sr, ser_in};

  // Shift one bit per enabled edge; clear once a word has been taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (en) begin
      sr <= word[W-2:0];
    end
  end

endmodule

// File: rtl/serial_dp_receiver.sv
// Serial data-point receiver for the LR front end.
// Deserialises NUM_DP points of NUM_DATA_WIDTH bits each (MSB first, no
// framing: the first edge after reset release carries the MSB of point 0),
// stores them in a small buffer and raises a sticky `done` once every point
// is captured. The compute core reads points back through rd_addr/rd_data.
//
// Output signalling: word_valid is a single-cycle qualifier with no ready
// back-pressure. word_data/word_addr are meaningful only in the cycle
// word_valid is 1; the consumer must take them in that cycle.
module serial_dp_receiver #(
  parameter int ADDR_WIDTH     = 3,
  parameter int MAX_FEATURES   = lr_pkg::MAX_FEATURES,
  parameter int MAX_DATA_WIDTH = lr_pkg::data_width(MAX_FEATURES),
  parameter int NUM_FEATURES   = 6,
  parameter int NUM_DATA_WIDTH = lr_pkg::data_width(NUM_FEATURES),
  parameter int NUM_DP         = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ser,
  output logic                      done,
  output logic                      word_valid,
  output logic [MAX_DATA_WIDTH-1:0] word_data,
  output logic [ADDR_WIDTH-1:0]     word_addr,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [MAX_DATA_WIDTH-1:0] rd_data
);

  import lr_pkg::*;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(NUM_DATA_WIDTH);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(NUM_DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_DP - 1);

  // Receiver state; a plain named register so checkers can bind to it.
  rx_state_e                     state;
  logic [CNT_W-1:0]              bit_cnt;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [DEPTH-1:0]              written;
  logic [NUM_DATA_WIDTH-1:0]     word_next;
  logic [MAX_DATA_WIDTH-1:0]     word_ext;
  logic                          capture;
  logic                          shift_en;
  logic                          rd_in_range;
  logic [MAX_DATA_WIDTH-1:0]     mem [DEPTH];

  // bit_cnt counts down to zero across a point; zero marks its last bit.
  assign capture  = (state == RECV) && (bit_cnt == '0);
  assign shift_en = (state == RECV) && (bit_cnt != '0);

  // Stored words are zero-extended to the full buffer width.
  assign word_ext = MAX_DATA_WIDTH'(word_next);

  // Addresses past the last point never hold data.
  assign rd_in_range = 32'(rd_addr) < NUM_DP;

  sipo_shift #(
    .W (NUM_DATA_WIDTH)
  ) u_sipo (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (capture),
    .en     (shift_en),
    .ser_in (ser),
    .word   (word_next)
  );

  // Receive FSM: bit/point counters, completion outputs and the written map.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= RECV;
      bit_cnt    <= CNT_LAST;
      wr_addr    <= '0;
      written    <= '0;
      done       <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_addr  <= '0;
    end else begin
      word_valid <= 1'b0;
      case (state)
        RECV: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end else begin
            word_data        <= word_ext;
            word_addr        <= wr_addr;
            word_valid       <= 1'b1;
            written[wr_addr] <= 1'b1;
            bit_cnt          <= CNT_LAST;
            wr_addr          <= wr_addr + ADDR_WIDTH'(1);
            if (wr_addr == LAST_ADDR) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          // Serial input is ignored; everything holds until reset.
          done <= 1'b1;
        end
        default: begin
          state <= RECV;
        end
      endcase
    end
  end

  // Point buffer write: one word per completed point.
  always_ff @(posedge CLK) begin
    if (capture) begin
      mem[wr_addr] <= word_ext;
    end
  end

  // Registered read port; unwritten or out-of-range slots read as zero and
  // a same-edge write is not forwarded (the old contents are returned).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data <= '0;
    end else if (rd_in_range && written[rd_addr]) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
